hit_conditioner: RTL

HIT_CONDITIONER -- requirements
Module: hit_conditioner

---
 rtl/hit_conditioner.sv | 132 +++++++++++++
 1 files changed

// File: rtl/hit_conditioner.sv
// Drum-pad input conditioning: synchronize and debounce the contacts, strobe
// accepted hits, hold per-channel flash levels for N frames, and keep session stats.
module hit_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 251000,
  parameter int unsigned HOLD_FRAMES     = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vsync,
  input  logic [2:0]  hit_raw,
  input  logic        timer_btn_raw,
  output logic [2:0]  hit_pulse,
  output logic [2:0]  hit_active,
  output logic        timer_run,
  output logic [23:0] hit_count,
  output logic [15:0] session_frames
);

  localparam int unsigned NCH       = 4;  // hat, cymbal, tom, timer button
  localparam int unsigned NHIT      = 3;
  localparam logic [17:0] DB_LAST   = 18'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]  HOLD_LOAD = 8'(HOLD_FRAMES);

  logic [NCH-1:0]        raw_in;
  logic [NCH-1:0]        sync1_q, sync2_q;
  logic [NCH-1:0]        stable_q, stable_d, stable_dly_q;
  logic [NCH-1:0][17:0]  db_cnt_q, db_cnt_d;
  logic [NCH-1:0]        rise;
  logic                  vs_s1_q, vs_s2_q, vs_prev_q;
  logic                  frame_tick_q, frame_tick_d;
  logic [NHIT-1:0]       hit_pulse_q, hit_pulse_d;
  logic [NHIT-1:0][7:0]  hold_q, hold_d;
  logic [NHIT-1:0]       hit_active_q, hit_active_d;
  logic                  timer_run_q, timer_run_d;
  logic                  timer_toggle;
  logic [23:0]           hit_count_q, hit_count_d;
  logic [15:0]           session_frames_q, session_frames_d;

  assign raw_in       = {timer_btn_raw, hit_raw};
  // Rising edge of the debounced level, seen one edge after stable changes.
  assign rise         = stable_q & ~stable_dly_q;
  assign timer_toggle = rise[3];

  // Debounce: count consecutive cycles where the synchronized level disagrees
  // with the accepted one; any agreement restarts the count.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    stable_d = stable_q;
    db_cnt_d = '0;
    for (int i = 0; i < NCH; i++) begin
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) stable_d[i] = sync2_q[i];
        else                        db_cnt_d[i] = db_cnt_q[i] + 18'd1;
      end
    end
  end

  always_comb begin
    hit_pulse_d  = rise[NHIT-1:0];
    frame_tick_d = vs_prev_q & ~vs_s2_q;
    hold_d       = hold_q;
    hit_active_d = '0;
    for (int c = 0; c < NHIT; c++) begin
      if (hit_pulse_q[c])                          hold_d[c] = HOLD_LOAD;
      else if (frame_tick_q && hold_q[c] != 8'd0)  hold_d[c] = hold_q[c] - 8'd1;
      hit_active_d[c] = (hold_d[c] != 8'd0);
    end
  end

  // Session statistics: a start clears everything; a stop simply stops counting,
  // so a pulse coinciding with either toggle is never counted.
  always_comb begin
    timer_run_d      = timer_run_q ^ timer_toggle;
    hit_count_d      = hit_count_q;
    session_frames_d = session_frames_q;
    if (timer_toggle && !timer_run_q) begin
      hit_count_d      = '0;
      session_frames_d = '0;
    end else if (timer_run_q && !timer_toggle) begin
      for (int c = 0; c < NHIT; c++) begin
        if (hit_pulse_q[c] && hit_count_q[c*8 +: 8] != 8'hFF)
          hit_count_d[c*8 +: 8] = hit_count_q[c*8 +: 8] + 8'd1;
      end
      if (frame_tick_q && session_frames_q != 16'hFFFF)
        session_frames_d = session_frames_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q          <= '0;
      sync2_q          <= '0;
      stable_q         <= '0;
      stable_dly_q     <= '0;
      db_cnt_q         <= '0;
      vs_s1_q          <= 1'b0;
      vs_s2_q          <= 1'b0;
      vs_prev_q        <= 1'b0;
      frame_tick_q     <= 1'b0;
      hit_pulse_q      <= '0;
      hold_q           <= '0;
      hit_active_q     <= '0;
      timer_run_q      <= 1'b0;
      hit_count_q      <= '0;
      session_frames_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values; chains like sync1->sync2 depend on it.
      sync1_q          <= raw_in;
      sync2_q          <= sync1_q;
      stable_q         <= stable_d;
      stable_dly_q     <= stable_q;
      db_cnt_q         <= db_cnt_d;
      vs_s1_q          <= vsync;
      vs_s2_q          <= vs_s1_q;
      vs_prev_q        <= vs_s2_q;
      frame_tick_q     <= frame_tick_d;
      hit_pulse_q      <= hit_pulse_d;
      hold_q           <= hold_d;
      hit_active_q     <= hit_active_d;
      timer_run_q      <= timer_run_d;
      hit_count_q      <= hit_count_d;
      session_frames_q <= session_frames_d;
    end
  end

  assign hit_pulse      = hit_pulse_q;
  assign hit_active     = hit_active_q;
  assign timer_run      = timer_run_q;
  assign hit_count      = hit_count_q;
  assign session_frames = session_frames_q;

endmodule
